// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: load-use stall detection, flush/bubble insertion,
// WB-to-operand bypass on capture and saturating bubble/flush counters.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [7:0]       id_ctrl,
    input  logic [3:0]       id_alu_op,
    input  logic             flush_ex,
    input  logic             wb_reg_write,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             stall_id,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [RA_W-1:0]  rs1_ex,
    output logic [RA_W-1:0]  rs2_ex,
    output logic [RA_W-1:0]  rd_ex,
    output logic [7:0]       ex_ctrl,
    output logic [3:0]       ex_alu_op,
    output logic [CNT_W-1:0] bubble_count,
    output logic [CNT_W-1:0] flush_count
);

    logic             ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]  ex_pc_q, ex_pc_d;
    logic [XLEN-1:0]  ex_rs1_data_q, ex_rs1_data_d;
    logic [XLEN-1:0]  ex_rs2_data_q, ex_rs2_data_d;
    logic [XLEN-1:0]  ex_imm_q, ex_imm_d;
    logic [RA_W-1:0]  rs1_ex_q, rs1_ex_d;
    logic [RA_W-1:0]  rs2_ex_q, rs2_ex_d;
    logic [RA_W-1:0]  rd_ex_q, rd_ex_d;
    logic [7:0]       ex_ctrl_q, ex_ctrl_d;
    logic [3:0]       ex_alu_op_q, ex_alu_op_d;
    logic [CNT_W-1:0] bubble_count_q, bubble_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic load_use;
    logic byp_rs1, byp_rs2;

    assign load_use = ex_valid_q & ex_ctrl_q[6] & (rd_ex_q != '0) & id_valid &
                      ((id_use_rs1 & (id_rs1 == rd_ex_q)) |
                       (id_use_rs2 & (id_rs2 == rd_ex_q)));
    assign stall_id = load_use & ~flush_ex;

    // x0 is hardwired, so a WB write to it must never leak into an operand
    assign byp_rs1 = wb_reg_write & (wb_rd != '0) & (wb_rd == id_rs1);
    assign byp_rs2 = wb_reg_write & (wb_rd != '0) & (wb_rd == id_rs2);

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_pc_d        = ex_pc_q;
        ex_rs1_data_d  = ex_rs1_data_q;
        ex_rs2_data_d  = ex_rs2_data_q;
        ex_imm_d       = ex_imm_q;
        rs1_ex_d       = rs1_ex_q;
        rs2_ex_d       = rs2_ex_q;
        rd_ex_d        = rd_ex_q;
        ex_ctrl_d      = ex_ctrl_q;
        ex_alu_op_d    = ex_alu_op_q;
        bubble_count_d = bubble_count_q;
        flush_count_d  = flush_count_q;

        if (flush_ex || load_use || !id_valid) begin
            // bubble: data fields deliberately hold
            ex_valid_d  = 1'b0;
            ex_ctrl_d   = '0;
            ex_alu_op_d = '0;
            rs1_ex_d    = '0;
            rs2_ex_d    = '0;
            rd_ex_d     = '0;
        end else begin
            ex_valid_d    = 1'b1;
            ex_pc_d       = id_pc;
            ex_rs1_data_d = byp_rs1 ? wb_data : id_rs1_data;
            ex_rs2_data_d = byp_rs2 ? wb_data : id_rs2_data;
            ex_imm_d      = id_imm;
            rs1_ex_d      = id_rs1;
            rs2_ex_d      = id_rs2;
            rd_ex_d       = id_rd;
            ex_ctrl_d     = id_ctrl;
            ex_alu_op_d   = id_alu_op;
        end

        if (flush_ex) begin
            if (id_valid && (flush_count_q != '1))
                flush_count_d = flush_count_q + 1'b1;
        end else if (load_use) begin
            if (bubble_count_q != '1)
                bubble_count_d = bubble_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q     <= 1'b0;
            ex_pc_q        <= '0;
            ex_rs1_data_q  <= '0;
            ex_rs2_data_q  <= '0;
            ex_imm_q       <= '0;
            rs1_ex_q       <= '0;
            rs2_ex_q       <= '0;
            rd_ex_q        <= '0;
            ex_ctrl_q      <= '0;
            ex_alu_op_q    <= '0;
            bubble_count_q <= '0;
            flush_count_q  <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_pc_q        <= ex_pc_d;
            ex_rs1_data_q  <= ex_rs1_data_d;
            ex_rs2_data_q  <= ex_rs2_data_d;
            ex_imm_q       <= ex_imm_d;
            rs1_ex_q       <= rs1_ex_d;
            rs2_ex_q       <= rs2_ex_d;
            rd_ex_q        <= rd_ex_d;
            ex_ctrl_q      <= ex_ctrl_d;
            ex_alu_op_q    <= ex_alu_op_d;
            bubble_count_q <= bubble_count_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_pc        = ex_pc_q;
    assign ex_rs1_data  = ex_rs1_data_q;
    assign ex_rs2_data  = ex_rs2_data_q;
    assign ex_imm       = ex_imm_q;
    assign rs1_ex       = rs1_ex_q;
    assign rs2_ex       = rs2_ex_q;
    assign rd_ex        = rd_ex_q;
    assign ex_ctrl      = ex_ctrl_q;
    assign ex_alu_op    = ex_alu_op_q;
    assign bubble_count = bubble_count_q;
    assign flush_count  = flush_count_q;

endmodule
